pmem_arbiter: RTL and testbench
===============================

# pmem_arbiter

Multi-channel line-burst arbiter between the core's caches and the single physical-memory port. Each channel (I-cache, D-cache, later prefetcher/victim buffer) issues whole-cacheline read or write requests. The block grants one channel at a time, round-robin or fixed priority, and runs the burst of `BURST_W`-bit beats on pmem. It returns the assembled line with a one-cycle response.

## Interface
- `NUM_CH`, default 2: number of requesting channels (≥1); channel 0 = I-cache, 1 = D-cache.
- `ADDR_W`, default 32: address width.
- `LINE_W`, default 256: cacheline width in bits.
- `BURST_W`, default 64: pmem beat width; `BEATS = LINE_W/BURST_W` (power of two, ≥1).
- `RR_MODE`, default 1: 1 = round-robin, 0 = fixed priority (lowest index wins).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ch_read`  in  NUM_CH  per-channel line read request, held until own `ch_resp`.
- `ch_write`  in  NUM_CH  per-channel line write request, held until own `ch_resp`.
- `ch_address`  in  NUM_CH×ADDR_W  per-channel line address.
- `ch_wdata`  in  NUM_CH×LINE_W  per-channel write line.
- `ch_resp`  out  NUM_CH  one-hot, single-cycle completion pulse.
- `ch_rdata`  out  LINE_W  shared read line; valid only while `ch_resp` is high after a read.
- `pmem_read`  out  1  pmem burst read.
- `pmem_write`  out  1  pmem burst write.
- `pmem_address`  out  ADDR_W  line-aligned burst address.
- `pmem_wdata`  out  BURST_W  current write beat.
- `pmem_rdata`  in  BURST_W  read beat.
- `pmem_resp`  in  1  beat accepted/returned, one pulse per beat.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: a channel is requesting if `ch_read|ch_write` is set.
  - Select the winner. Round-robin searches from `rr_ptr` upward, modulo NUM_CH. Fixed mode takes the lowest index.
  - Latch the winner's index, its address with the low log2(LINE_W/8) bits forced to 0, and its wdata. Clear `beat_cnt`.
  - Go to WRITE if the winner's `ch_write` is set, else READ. Write wins if a channel asserts both.
  - RR mode only: `rr_ptr ← grant+1 mod NUM_CH`.
  - No requests: stay in IDLE.
- READ: `pmem_read`=1. On each `pmem_resp`, store `pmem_rdata` into line slice [beat_cnt] and increment `beat_cnt`. The response on beat `BEATS-1` moves to DONE.
- WRITE: `pmem_write`=1 and `pmem_wdata` = latched line slice [beat_cnt]. Beats advance on `pmem_resp` as in READ; the last beat moves to DONE.
- DONE: `ch_resp[grant]`=1 for exactly one cycle. `ch_rdata` holds the assembled line (write: contents undefined-but-stable, value is don't-care). Go to IDLE next cycle.
- Requests from non-granted channels and changes to the granted channel's inputs after the grant are ignored until IDLE.
- `pmem_resp` outside READ/WRITE is ignored.
- `beat_cnt` is log2(BEATS) bits (1 bit min) and wraps naturally on the last beat.

## Timing
- Reset values: `pmem_read`=0, `pmem_write`=0, `pmem_address`=0, `pmem_wdata`=0, `ch_resp`=0, `ch_rdata`=0, state IDLE, `rr_ptr`=0, `beat_cnt`=0.
- Reset asserted mid-burst: pmem strobes drop asynchronously, the burst is abandoned, and no `ch_resp` is issued. The requester re-issues after reset.
- Request seen in IDLE at cycle t gives `pmem_read`/`pmem_write` high from cycle t+1. With `pmem_resp` every cycle, `ch_resp` fires at cycle t+BEATS+1. Wait states add 1:1.
- `pmem_address`, `pmem_read`/`pmem_write` stay constant for the whole burst; `pmem_wdata` changes only after a `pmem_resp` edge.
- Requester deasserts in the cycle after `ch_resp`. IDLE is entered that cycle, so re-arbitration never sees the stale request.
- Back-to-back grants: a minimum of one IDLE cycle separates bursts.
- Outputs are registered or decoded from registered state only; there is no combinational path from `ch_*` to `pmem_*`.

## Structure
- A shared package `arb_types` holds `arb_state_t` (IDLE/READ/WRITE/DONE) and the beat-index width function. Existing `rv32i_types` is untouched apart from reusing `rv32i_word` when `ADDR_W`=32.
- One sub-module `rr_grant`: request vector plus pointer plus mode in, one-hot grant and index out, purely combinational.
- `rr_ptr` lives in `pmem_arbiter`.

## Test plan
- Single read: ch0 read, addr 0x0000_1234, pmem returns beats 0x11…, 0x22…, 0x33…, 0x44… on consecutive cycles. Required: `pmem_address`=0x0000_1220, `ch_resp`=01 at cycle 5, `ch_rdata`={0x44…,0x33…,0x22…,0x11…}.
- Write with wait states: ch1 writes line 0xDEAD…; pmem_resp every 3rd cycle. Required: beats emitted low slice first, each held until its resp; `ch_resp`=10 after 4th resp+1.
- RR contention: ch0 and ch1 continuously requesting, RR_MODE=1. Required: grants alternate 0,1,0,1 starting from 0. With RR_MODE=0, ch0 is granted every time.
- Read+write same channel: ch1 asserts both. Required: a WRITE burst is issued.
- Reset mid-burst: assert `rst` after beat 2 of a read. Required: `pmem_read`=0 immediately, no `ch_resp`, `rr_ptr`=0, and a fresh request after reset restarts at beat 0.
- Spurious `pmem_resp` in IDLE. Required: no state change, no `ch_resp`.

Source files
------------

// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory arbiter.
package arb_types;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } arb_state_t;

  // Width of an index over n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pmem_arbiter_rr_grant.sv
// Combinational grant selector: round-robin from a pointer, or lowest index first.
module rr_grant #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              rr_mode,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  index,
  output logic              valid
);

  int unsigned cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk the channels in search order and take the first requester found.
  always_comb begin
    grant    = '0;
    index    = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand     = rr_mode ? ((32'(ptr) + i) % NUM_CH) : i;
      cand_idx = IDX_W'(cand);
      if (!valid && req[cand_idx]) begin
        valid           = 1'b1;
        index           = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Line-burst arbiter: grants one cache channel at a time and runs its
// whole-line read or write as a burst of beats on the physical-memory port.
module pmem_arbiter
  import arb_types::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64,
  parameter int unsigned RR_MODE = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              ch_read,
  input  logic [NUM_CH-1:0]              ch_write,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_address,
  input  logic [NUM_CH-1:0][LINE_W-1:0]  ch_wdata,
  output logic [NUM_CH-1:0]              ch_resp,
  output logic [LINE_W-1:0]              ch_rdata,
  output logic                           pmem_read,
  output logic                           pmem_write,
  output logic [ADDR_W-1:0]              pmem_address,
  output logic [BURST_W-1:0]             pmem_wdata,
  input  logic [BURST_W-1:0]             pmem_rdata,
  input  logic                           pmem_resp
);

  localparam int unsigned BEATS  = LINE_W / BURST_W;
  localparam int unsigned IDX_W  = idx_width(NUM_CH);
  localparam int unsigned BEAT_W = idx_width(BEATS);
  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);
  localparam logic [IDX_W-1:0]  LAST_CH    = IDX_W'(NUM_CH - 1);

  arb_state_t state, state_next;

  logic [NUM_CH-1:0]              req;
  logic [NUM_CH-1:0]              win_onehot;
  logic [IDX_W-1:0]               win_idx;
  logic                           win_valid;
  logic [IDX_W-1:0]               rr_ptr;
  logic [NUM_CH-1:0]              grant_oh;
  logic [ADDR_W-1:0]              addr_q;
  logic [BEATS-1:0][BURST_W-1:0]  line_q;
  logic [BEAT_W-1:0]              beat_cnt;
  logic                           take_grant;
  logic                           beat_done;

  assign req        = ch_read | ch_write;
  assign take_grant = (state == IDLE) && win_valid;
  assign beat_done  = pmem_resp && ((state == READ) || (state == WRITE));

  rr_grant #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr_grant (
    .req     (req),
    .ptr     (rr_ptr),
    .rr_mode (RR_MODE != 0),
    .grant   (win_onehot),
    .index   (win_idx),
    .valid   (win_valid)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: arbitrate in IDLE, count beats, one-cycle DONE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (win_valid) begin
          state_next = ch_write[win_idx] ? WRITE : READ;
        end
      end
      READ, WRITE: begin
        if (beat_done && (beat_cnt == LAST_BEAT)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Burst datapath: the line buffer carries the write line out and the read
  // line back in, so one register serves both directions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      line_q   <= '0;
      beat_cnt <= '0;
      grant_oh <= '0;
      rr_ptr   <= '0;
    end else begin
      if (take_grant) begin
        addr_q   <= ch_address[win_idx] & ALIGN_MASK;
        line_q   <= ch_wdata[win_idx];
        beat_cnt <= '0;
        grant_oh <= win_onehot;
        if (RR_MODE != 0) begin
          rr_ptr <= (win_idx == LAST_CH) ? '0 : win_idx + 1'b1;
        end
      end
      if (beat_done) begin
        if (state == READ) begin
          line_q[beat_cnt] <= pmem_rdata;
        end
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    pmem_read    = (state == READ);
    pmem_write   = (state == WRITE);
    pmem_address = addr_q;
    pmem_wdata   = (state == WRITE) ? line_q[beat_cnt] : '0;
    ch_resp      = (state == DONE) ? grant_oh : '0;
    ch_rdata     = line_q;
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: a round-robin instance and a
// fixed-priority instance driven from the same stimulus.
module tb_pmem_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        ch_read, ch_write;
  logic [1:0][31:0]  ch_address;
  logic [1:0][255:0] ch_wdata;
  logic [63:0]       pmem_rdata;
  logic              pmem_resp;

  logic [1:0]   ch_resp,      fx_ch_resp;
  logic [255:0] ch_rdata,     fx_ch_rdata;
  logic         pmem_read,    fx_pmem_read;
  logic         pmem_write,   fx_pmem_write;
  logic [31:0]  pmem_address, fx_pmem_address;
  logic [63:0]  pmem_wdata,   fx_pmem_wdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pmem_arbiter #(.NUM_CH(2), .ADDR_W(32), .LINE_W(256), .BURST_W(64), .RR_MODE(1)) dut (
    .clk(clk), .rst(rst), .ch_read(ch_read), .ch_write(ch_write),
    .ch_address(ch_address), .ch_wdata(ch_wdata), .ch_resp(ch_resp), .ch_rdata(ch_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  pmem_arbiter #(.NUM_CH(2), .ADDR_W(32), .LINE_W(256), .BURST_W(64), .RR_MODE(0)) dut_fx (
    .clk(clk), .rst(rst), .ch_read(ch_read), .ch_write(ch_write),
    .ch_address(ch_address), .ch_wdata(ch_wdata), .ch_resp(fx_ch_resp), .ch_rdata(fx_ch_rdata),
    .pmem_read(fx_pmem_read), .pmem_write(fx_pmem_write), .pmem_address(fx_pmem_address),
    .pmem_wdata(fx_pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  function automatic logic [255:0] rnd_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic pulse_reset();
    rst = 1'b1; ch_read = '0; ch_write = '0; pmem_resp = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Drives one transaction on one channel and acts as the memory, asserting
  // pmem_resp on every gap-th strobed cycle. Returns what it observed.
  task automatic do_burst(input int ch, input bit rd, input bit wr,
                          input logic [31:0] addr, input logic [255:0] wline,
                          input logic [255:0] rline, input int gap,
                          output logic [31:0] o_addr, output bit o_rd, output bit o_wr,
                          output logic [255:0] o_wbeats, output logic [255:0] o_rdata,
                          output logic [1:0] o_resp, output int o_lat, output int o_unstable);
    int c, k, bn;
    bit seen, done, prev_resp;
    logic [63:0] prev_wd;
    ch_read = '0; ch_write = '0;
    ch_read[ch] = rd; ch_write[ch] = wr;
    ch_address[ch] = addr; ch_wdata[ch] = wline;
    o_addr = '0; o_rd = 0; o_wr = 0; o_wbeats = '0; o_rdata = '0; o_resp = '0;
    o_lat = -1; o_unstable = 0;
    c = 0; k = 0; bn = 0; seen = 0; done = 0; prev_resp = 0; prev_wd = '0;
    while (!done && c < 200) begin
      @(posedge clk); #1;
      c++;
      pmem_resp = 1'b0;
      if (c == 2) begin
        ch_address[ch] = $urandom;
        ch_wdata[ch]   = rnd_line();
      end
      if (ch_resp != 2'b00) begin
        o_resp = ch_resp; o_rdata = ch_rdata; o_lat = c; done = 1;
      end else if (pmem_read || pmem_write) begin
        if (!seen) begin
          seen = 1; o_addr = pmem_address; o_rd = pmem_read; o_wr = pmem_write;
        end else begin
          if (pmem_address !== o_addr || pmem_read !== o_rd || pmem_write !== o_wr) o_unstable++;
          if (pmem_write && !prev_resp && pmem_wdata !== prev_wd) o_unstable++;
        end
        prev_wd = pmem_wdata;
        k++;
        if (k % gap == 0 && bn < 4) begin
          pmem_resp = 1'b1;
          pmem_rdata = rline[bn*64 +: 64];
          o_wbeats[bn*64 +: 64] = pmem_wdata;
          bn++;
        end
        prev_resp = pmem_resp;
      end
    end
    @(posedge clk); #1;
    if (ch_resp !== 2'b00) o_unstable++;
    pmem_resp = 1'b0; ch_read = '0; ch_write = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ch_read = '0; ch_write = '0; pmem_resp = 1'b0; pmem_rdata = '0;
    ch_address = '0; ch_wdata = '0;
    @(posedge clk); #1;
    checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b want 00", {pmem_read, pmem_write}); end
    checks++; if (pmem_address !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", pmem_address); end
    checks++; if (pmem_wdata !== 64'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", pmem_wdata); end
    checks++; if (ch_resp !== 2'b00) begin errors++; $display("FAIL reset_resp: got %b want 00", ch_resp); end
    checks++; if (ch_rdata !== 256'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", ch_rdata); end
    checks++; if ({fx_pmem_read, fx_pmem_write, fx_ch_resp} !== 4'b0) begin errors++; $display("FAIL reset_fx: got %b want 0000", {fx_pmem_read, fx_pmem_write, fx_ch_resp}); end
    checks++; if ({fx_pmem_address, fx_pmem_wdata, fx_ch_rdata} !== '0) begin errors++; $display("FAIL reset_fx_data: got nonzero want 0"); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    logic [255:0] rline, wb, rd;
    logic [31:0] a, addr; logic [1:0] r; bit ord, owr; int lat, uns, ch, gap;
    rline = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    do_burst(0, 1, 0, 32'h0000_1234, '0, rline, 1, a, ord, owr, wb, rd, r, lat, uns);
    checks++; if (a !== 32'h0000_1220) begin errors++; $display("FAIL read_addr: got %h want 00001220", a); end
    checks++; if ({ord, owr} !== 2'b10) begin errors++; $display("FAIL read_kind: got %b want 10", {ord, owr}); end
    checks++; if (r !== 2'b01) begin errors++; $display("FAIL read_resp: got %b want 01", r); end
    checks++; if (lat != 5) begin errors++; $display("FAIL read_latency: got %0d want 5", lat); end
    checks++; if (rd !== rline) begin errors++; $display("FAIL read_line: got %h want %h", rd, rline); end
    checks++; if (uns != 0) begin errors++; $display("FAIL read_stable: got %0d want 0", uns); end
    for (int i = 0; i < 4; i++) begin
      ch = $urandom_range(0, 1); gap = $urandom_range(1, 3);
      addr = $urandom; rline = rnd_line();
      do_burst(ch, 1, 0, addr, rnd_line(), rline, gap, a, ord, owr, wb, rd, r, lat, uns);
      checks++; if (a !== (addr & ~32'h1F)) begin errors++; $display("FAIL rnd_read_addr: got %h want %h", a, addr & ~32'h1F); end
      checks++; if (r !== 2'(1 << ch)) begin errors++; $display("FAIL rnd_read_resp: got %b want ch%0d", r, ch); end
      checks++; if (lat != 1 + 4 * gap) begin errors++; $display("FAIL rnd_read_latency: got %0d want %0d", lat, 1 + 4 * gap); end
      checks++; if (rd !== rline) begin errors++; $display("FAIL rnd_read_line: got %h want %h", rd, rline); end
      checks++; if (uns != 0) begin errors++; $display("FAIL rnd_read_stable: got %0d want 0", uns); end
    end
  endtask

  task automatic test_write_wait();
    logic [255:0] wline, wb, rd;
    logic [31:0] a, addr; logic [1:0] r; bit ord, owr; int lat, uns, ch, gap;
    wline = {64'hDEAD_0000_0000_0003, 64'hDEAD_0000_0000_0002, 64'hDEAD_0000_0000_0001, 64'hDEAD_0000_0000_0000};
    do_burst(1, 0, 1, 32'h8000_0040, wline, '0, 3, a, ord, owr, wb, rd, r, lat, uns);
    checks++; if ({ord, owr} !== 2'b01) begin errors++; $display("FAIL write_kind: got %b want 01", {ord, owr}); end
    checks++; if (wb !== wline) begin errors++; $display("FAIL write_beats: got %h want %h", wb, wline); end
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL write_resp: got %b want 10", r); end
    checks++; if (lat != 13) begin errors++; $display("FAIL write_latency: got %0d want 13", lat); end
    checks++; if (uns != 0) begin errors++; $display("FAIL write_stable: got %0d want 0", uns); end
    for (int i = 0; i < 3; i++) begin
      ch = $urandom_range(0, 1); gap = $urandom_range(1, 4);
      addr = $urandom; wline = rnd_line();
      do_burst(ch, 0, 1, addr, wline, rnd_line(), gap, a, ord, owr, wb, rd, r, lat, uns);
      checks++; if (a !== (addr & ~32'h1F)) begin errors++; $display("FAIL rnd_write_addr: got %h want %h", a, addr & ~32'h1F); end
      checks++; if (wb !== wline) begin errors++; $display("FAIL rnd_write_beats: got %h want %h", wb, wline); end
      checks++; if (lat != 1 + 4 * gap) begin errors++; $display("FAIL rnd_write_latency: got %0d want %0d", lat, 1 + 4 * gap); end
      checks++; if (uns != 0) begin errors++; $display("FAIL rnd_write_stable: got %0d want 0", uns); end
    end
  endtask

  task automatic test_read_write_same();
    logic [255:0] wline, wb, rd;
    logic [31:0] a; logic [1:0] r; bit ord, owr; int lat, uns;
    wline = rnd_line();
    do_burst(1, 1, 1, $urandom, wline, rnd_line(), 1, a, ord, owr, wb, rd, r, lat, uns);
    checks++; if ({ord, owr} !== 2'b01) begin errors++; $display("FAIL rw_kind: got %b want 01", {ord, owr}); end
    checks++; if (wb !== wline) begin errors++; $display("FAIL rw_beats: got %h want %h", wb, wline); end
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL rw_resp: got %b want 10", r); end
  endtask

  task automatic test_contention();
    int c, n_rr, n_fx, last, exp_rr;
    pulse_reset();
    ch_address[0] = $urandom; ch_address[1] = $urandom;
    ch_read = 2'b11; ch_write = 2'b00; pmem_resp = 1'b1; pmem_rdata = {$urandom, $urandom};
    c = 0; n_rr = 0; n_fx = 0; last = -1; exp_rr = 0;
    while ((n_rr < 4 || n_fx < 4) && c < 100) begin
      @(posedge clk); #1;
      c++;
      if (ch_resp != 2'b00 && n_rr < 4) begin
        checks++; if (ch_resp !== 2'(1 << exp_rr)) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", n_rr, ch_resp, 2'(1 << exp_rr)); end
        if (last >= 0) begin
          checks++; if (c - last != 6) begin errors++; $display("FAIL rr_spacing: got %0d want 6", c - last); end
        end
        last = c; exp_rr = (exp_rr + 1) % 2; n_rr++;
      end
      if (fx_ch_resp != 2'b00 && n_fx < 4) begin
        checks++; if (fx_ch_resp !== 2'b01) begin errors++; $display("FAIL fixed_grant%0d: got %b want 01", n_fx, fx_ch_resp); end
        n_fx++;
      end
    end
    checks++; if (n_rr != 4 || n_fx != 4) begin errors++; $display("FAIL contention_timeout: got rr=%0d fx=%0d want 4/4", n_rr, n_fx); end
    pulse_reset();
  endtask

  task automatic test_reset_mid_burst();
    logic [255:0] rline, wb, rd;
    logic [31:0] a; logic [1:0] r, seen_resp; bit ord, owr; int lat, uns, c;
    ch_read = 2'b01; ch_address[0] = $urandom; pmem_rdata = {$urandom, $urandom};
    @(posedge clk); #1; pmem_resp = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; pmem_resp = 1'b0;
    checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL midrst_pre: got %b want 1", pmem_read); end
    #2 rst = 1'b1;
    #1;
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL midrst_strobe: got %b want 0", pmem_read); end
    ch_read = '0;
    seen_resp = '0;
    repeat (3) begin @(posedge clk); #1; seen_resp |= ch_resp; end
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; seen_resp |= ch_resp; end
    checks++; if (seen_resp !== 2'b00) begin errors++; $display("FAIL midrst_noresp: got %b want 00", seen_resp); end
    // Both channels request: a cleared pointer grants channel 0 first.
    ch_read = 2'b11; pmem_resp = 1'b1; r = '0; c = 0;
    while (r == 2'b00 && c < 20) begin @(posedge clk); #1; c++; r = ch_resp; end
    ch_read = '0; pmem_resp = 1'b0;
    @(posedge clk); #1;
    checks++; if (r !== 2'b01) begin errors++; $display("FAIL midrst_ptr: got %b want 01", r); end
    rline = rnd_line();
    do_burst(0, 1, 0, $urandom, '0, rline, 1, a, ord, owr, wb, rd, r, lat, uns);
    checks++; if (rd !== rline) begin errors++; $display("FAIL midrst_fresh_line: got %h want %h", rd, rline); end
    checks++; if (lat != 5) begin errors++; $display("FAIL midrst_fresh_latency: got %0d want 5", lat); end
  endtask

  task automatic test_spurious_resp();
    logic [255:0] rline, wb, rd;
    logic [31:0] a; logic [1:0] r; bit ord, owr; int lat, uns;
    ch_read = '0; ch_write = '0;
    for (int i = 0; i < 4; i++) begin
      pmem_resp = 1'b1; pmem_rdata = {$urandom, $urandom};
      @(posedge clk); #1;
      checks++; if ({pmem_read, pmem_write, ch_resp} !== 4'b0000) begin errors++; $display("FAIL spurious_idle%0d: got %b want 0000", i, {pmem_read, pmem_write, ch_resp}); end
    end
    pmem_resp = 1'b0;
    rline = rnd_line();
    do_burst(1, 1, 0, $urandom, '0, rline, 2, a, ord, owr, wb, rd, r, lat, uns);
    checks++; if (rd !== rline) begin errors++; $display("FAIL spurious_after_line: got %h want %h", rd, rline); end
    checks++; if (lat != 9) begin errors++; $display("FAIL spurious_after_latency: got %0d want 9", lat); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_wait();
    test_read_write_same();
    test_contention();
    test_reset_mid_burst();
    test_spurious_resp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
